// File: rtl/axi_lite_rd_arbiter.sv
// Two-master AXI-lite read arbiter (IFU, LSU) onto one slave AR/R port.
// One transaction in flight; round-robin on contention.
module axi_lite_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_arvalid,
  input  logic [ADDR_W-1:0] ifu_araddr,
  output logic              ifu_arready,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  input  logic              lsu_arvalid,
  input  logic [ADDR_W-1:0] lsu_araddr,
  output logic              lsu_arready,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [DATA_W-1:0] m_rdata,
  output logic [1:0]        m_rresp,
  output logic              s_arvalid,
  output logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arready,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic last_lsu;
  logic pick_ifu;
  logic pick_lsu;
  logic win;
  logic r_done;

  // Winner selection; a tie goes to the master that did not own the last one.
  // Gated by rst so no request is acknowledged while reset is held.
  always_comb begin
    pick_ifu = rst & ifu_arvalid & (~lsu_arvalid | last_lsu);
    pick_lsu = rst & lsu_arvalid & (~ifu_arvalid | ~last_lsu);
    win      = pick_ifu | pick_lsu;
  end

  // Next state and handshake outputs; data path is pure pass-through.
  always_comb begin
    state_nx    = state;
    ifu_arready = 1'b0;
    lsu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_rvalid  = 1'b0;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    r_done      = 1'b0;
    m_rdata     = s_rdata;
    m_rresp     = s_rresp;
    unique case (state)
      IDLE: begin
        ifu_arready = pick_ifu;
        lsu_arready = pick_lsu;
        if (win) state_nx = ADDR;
      end
      ADDR: begin
        s_arvalid = 1'b1;
        if (s_arready) state_nx = DATA;
      end
      DATA: begin
        unique case (1'b1)
          grant[0]: begin
            ifu_rvalid = s_rvalid;
            s_rready   = ifu_rready;
          end
          grant[1]: begin
            lsu_rvalid = s_rvalid;
            s_rready   = lsu_rready;
          end
          default: s_rready = 1'b0;
        endcase
        r_done = s_rvalid & s_rready;
        if (r_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Capture winner address and owner on acceptance; release owner on R handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_araddr <= '0;
      grant    <= 2'b00;
      last_lsu <= 1'b1;
    end else begin
      if (state == IDLE && win) begin
        s_araddr <= pick_ifu ? ifu_araddr : lsu_araddr;
        grant    <= {pick_lsu, pick_ifu};
      end
      if (r_done) begin
        last_lsu <= grant[1];
        grant    <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Bench for axi_lite_rd_arbiter: vector table of read transactions,
// scoreboard of expected beats, plus reset sequences.
module tb_axi_lite_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;

  logic          clk;
  logic          rst;
  logic          ifu_arvalid;
  logic [AW-1:0] ifu_araddr;
  logic          ifu_arready;
  logic          ifu_rvalid;
  logic          ifu_rready;
  logic          lsu_arvalid;
  logic [AW-1:0] lsu_araddr;
  logic          lsu_arready;
  logic          lsu_rvalid;
  logic          lsu_rready;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          s_arvalid;
  logic [AW-1:0] s_araddr;
  logic          s_arready;
  logic          s_rvalid;
  logic          s_rready;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic [1:0]    grant;

  axi_lite_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr),
    .ifu_arready(ifu_arready), .ifu_rvalid(ifu_rvalid),
    .ifu_rready(ifu_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr),
    .lsu_arready(lsu_arready), .lsu_rvalid(lsu_rvalid),
    .lsu_rready(lsu_rready),
    .m_rdata(m_rdata), .m_rresp(m_rresp),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr),
    .s_arready(s_arready), .s_rvalid(s_rvalid),
    .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic          lv;
    logic [AW-1:0] ia;
    logic [AW-1:0] la;
    int            ad;
    int            rd;
    int            bp;
    logic [DW-1:0] d;
    logic [1:0]    r;
    logic [1:0]    em;
  } vec_t;

  typedef struct {
    logic [1:0]    m;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[9];
  int   tests;
  int   fails;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_rready(input logic [1:0] m, input logic v);
    if (m == 2'b01) ifu_rready = v;
    else            lsu_rready = v;
  endtask

  // Called just after a negedge with the DUT in IDLE.
  task automatic run_vec(input vec_t v);
    exp_t e;
    exp_t g;
    ifu_arvalid = v.iv;
    lsu_arvalid = v.lv;
    ifu_araddr  = v.ia;
    lsu_araddr  = v.la;
    s_arready   = 1'b0;
    s_rvalid    = 1'b0;
    ifu_rready  = 1'b1;
    lsu_rready  = 1'b1;
    e.m    = v.em;
    e.addr = (v.em == 2'b01) ? v.ia : v.la;
    e.data = v.d;
    e.resp = v.r;
    sb.push_back(e);
    #1;
    chk("ifu_arready", ifu_arready, v.em == 2'b01);
    chk("lsu_arready", lsu_arready, v.em == 2'b10);
    @(negedge clk);
    if (v.em == 2'b01) ifu_araddr = ~v.ia;
    else               lsu_araddr = ~v.la;
    #1;
    chk("s_arvalid", s_arvalid, 1);
    chk("s_araddr", s_araddr, sb[0].addr);
    chk("grant", grant, v.em);
    chk("arready_addr", {ifu_arready, lsu_arready}, 0);
    for (int i = 0; i < v.ad; i++) begin
      @(negedge clk);
      #1;
      chk("s_arvalid_hold", s_arvalid, 1);
      chk("s_araddr_hold", s_araddr, sb[0].addr);
    end
    s_arready = 1'b1;
    @(negedge clk);
    s_arready = 1'b0;
    #1;
    chk("s_arvalid_data", s_arvalid, 0);
    for (int i = 0; i < v.rd; i++) begin
      chk("rvalid_wait", {ifu_rvalid, lsu_rvalid}, 0);
      @(negedge clk);
      #1;
    end
    s_rvalid = 1'b1;
    s_rdata  = v.d;
    s_rresp  = v.r;
    if (v.bp > 0) set_rready(v.em, 1'b0);
    for (int i = 0; i < v.bp; i++) begin
      #1;
      chk("s_rready_bp", s_rready, 0);
      chk("grant_bp", grant, v.em);
      @(negedge clk);
    end
    set_rready(v.em, 1'b1);
    #1;
    g = sb.pop_front();
    chk("s_rready", s_rready, 1);
    chk("rvalid_route", {lsu_rvalid, ifu_rvalid}, g.m);
    chk("m_rdata", m_rdata, g.data);
    chk("m_rresp", m_rresp, g.resp);
    @(negedge clk);
    s_rvalid = 1'b0;
    #1;
    chk("grant_idle", grant, 0);
    chk("s_rready_idle", s_rready, 0);
    chk("s_arvalid_idle", s_arvalid, 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    tbl[0] = '{1, 1, 32'h8000_0000, 32'h0000_1000, 0, 0, 0,
               64'hDEADBEEF_00100073, 2'b00, 2'b01};
    tbl[1] = '{1, 1, 32'h8000_0004, 32'h0000_1008, 0, 0, 0,
               64'h1111_2222_3333_4444, 2'b00, 2'b10};
    tbl[2] = '{1, 1, 32'h8000_0008, 32'h0000_1010, 1, 0, 0,
               64'h5555_6666_7777_8888, 2'b00, 2'b01};
    tbl[3] = '{1, 1, 32'h8000_000C, 32'h0000_1018, 0, 1, 0,
               64'h9999_AAAA_BBBB_CCCC, 2'b00, 2'b10};
    tbl[4] = '{1, 0, 32'h8000_0100, 32'h0, 3, 2, 0,
               64'h0123_4567_89AB_CDEF, 2'b00, 2'b01};
    tbl[5] = '{0, 1, 32'h0, 32'h0000_2000, 0, 0, 2,
               64'hCAFE_F00D_0000_0001, 2'b00, 2'b10};
    tbl[6] = '{0, 1, 32'h0, 32'h0000_2004, 0, 0, 0,
               64'hBAD0_BAD0_BAD0_BAD0, 2'b10, 2'b10};
    tbl[7] = '{1, 0, 32'h8000_0200, 32'h0, 0, 1, 0,
               64'hFFFF_0000_FFFF_0000, 2'b11, 2'b01};
    tbl[8] = '{1, 1, 32'h8000_0300, 32'h0000_3000, 0, 0, 0,
               64'h0F0F_0F0F_F0F0_F0F0, 2'b00, 2'b10};

    rst         = 1'b0;
    ifu_arvalid = 1'b1;
    lsu_arvalid = 1'b1;
    ifu_araddr  = 32'h8000_0000;
    lsu_araddr  = 32'h0000_1000;
    ifu_rready  = 1'b1;
    lsu_rready  = 1'b1;
    s_arready   = 1'b0;
    s_rvalid    = 1'b1;
    s_rdata     = '0;
    s_rresp     = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_arready", {ifu_arready, lsu_arready}, 0);
      chk("rst_rvalid", {ifu_rvalid, lsu_rvalid}, 0);
      chk("rst_s_arvalid", s_arvalid, 0);
      chk("rst_s_rready", s_rready, 0);
      chk("rst_grant", grant, 0);
      chk("rst_s_araddr", s_araddr, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    ifu_arvalid = 1'b1;
    lsu_arvalid = 1'b0;
    ifu_araddr  = 32'h8000_0400;
    @(negedge clk);
    ifu_arvalid = 1'b0;
    s_arready   = 1'b1;
    @(negedge clk);
    s_arready = 1'b0;
    s_rvalid  = 1'b1;
    #1;
    chk("pre_rst_grant", grant, 2'b01);
    chk("pre_rst_rvalid", ifu_rvalid, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_rvalid", ifu_rvalid, 0);
    chk("mid_rst_s_rready", s_rready, 0);
    @(posedge clk);
    #1;
    chk("post_rst_grant", grant, 0);
    chk("post_rst_s_arvalid", s_arvalid, 0);
    @(negedge clk);
    rst      = 1'b1;
    s_rvalid = 1'b0;
    tbl[0].ia = 32'h8000_0500;
    run_vec(tbl[0]);
    ifu_arvalid = 1'b0;
    lsu_arvalid = 1'b0;
    @(negedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
